rand_fill: RTL

Parametrised LFSR memory filler; writes a pseudo-random pattern into a frame or pattern RAM, one word per cycle, from address 0 to DEPTH-1.
Adds a start/done handshake, loadable seed, multi-bit words and write backpressure.
With DATA_W=1, TAPS=32'h8020_0003 and matching seed, the bit stream is identical to the free-running single-bit filler.
Sits between control logic and a RAM write port. Typical use: power-up fill, or re-fill of static/noise images.

---
 rtl/rand_fill_pkg.sv | 32 +++
 rtl/rand_fill_lfsr.sv | 35 +++
 rtl/rand_fill.sv | 115 +++++++++++
 3 files changed

// File: rtl/rand_fill_pkg.sv
// Shared definitions for the LFSR memory filler: FSM states, default LFSR constants,
// and the multi-step Fibonacci LFSR function used by rand_fill_lfsr.
package rand_fill_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [31:0] DEFAULT_TAPS = 32'h8020_0003;
    localparam logic [31:0] DEFAULT_SEED = 32'h0000_0001;

    // Widest LFSR the step function supports; narrower registers are zero-extended.
    localparam int LFSR_MAX_W = 64;

    // Bits above the caller's width never reach the feedback because the taps there are zero,
    // so the low LFSR_W bits of the result are exact for any LFSR_W <= LFSR_MAX_W.
    function automatic logic [LFSR_MAX_W-1:0] lfsr_step_n(
        input logic [LFSR_MAX_W-1:0] l,
        input logic [LFSR_MAX_W-1:0] taps,
        input int                    n
    );
        logic [LFSR_MAX_W-1:0] s;
        s = l;
        for (int k = 0; k < n; k++) begin
            s = {s[LFSR_MAX_W-2:0], ^(s & taps)};
        end
        return s;
    endfunction

endpackage

// File: rtl/rand_fill_lfsr.sv
// Fibonacci LFSR register that advances STEP steps per enabled cycle, with a
// loadable seed; a zero seed is replaced by SEED so the register cannot lock up.
module rand_fill_lfsr
    import rand_fill_pkg::*;
#(
    parameter int                LFSR_W = 32,
    parameter logic [LFSR_W-1:0] TAPS   = LFSR_W'(DEFAULT_TAPS),
    parameter int                STEP   = 1,
    parameter logic [LFSR_W-1:0] SEED   = LFSR_W'(DEFAULT_SEED)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [LFSR_W-1:0] seed,
    input  logic              advance,
    output logic [LFSR_W-1:0] state
);

    logic [LFSR_MAX_W-1:0] stepped;
    logic                  unused_stepped;

    assign stepped        = lfsr_step_n(LFSR_MAX_W'(state), LFSR_MAX_W'(TAPS), STEP);
    assign unused_stepped = ^stepped;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SEED;
        end else if (load) begin
            state <= (seed == '0) ? SEED : seed;
        end else if (advance) begin
            state <= stepped[LFSR_W-1:0];
        end
    end

endmodule

// File: rtl/rand_fill.sv
// LFSR memory filler: writes one pseudo-random word per accepted cycle from address 0 to DEPTH-1.
// Optional RAND_FILL_LOOP_EN: refill continuously with a one-cycle o_done pulse per pass.
module rand_fill
    import rand_fill_pkg::*;
#(
    parameter int                ADDR_W = 16,
    parameter int                DEPTH  = 2**ADDR_W,
    parameter int                DATA_W = 1,
    parameter int                LFSR_W = 32,
    parameter logic [LFSR_W-1:0] TAPS   = LFSR_W'(DEFAULT_TAPS),
    parameter logic [LFSR_W-1:0] SEED   = LFSR_W'(DEFAULT_SEED)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_seed_load,
    input  logic [LFSR_W-1:0] i_seed,
    input  logic              i_stall,
    output logic [ADDR_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_dat,
    output logic              o_we,
    output logic              o_busy,
    output logic              o_done
);

    // state | meaning
    // IDLE  | after reset, no writes; seed load and start accepted
    // FILL  | writing one word per non-stalled cycle
    // DONE  | pass complete, o_done held; seed load and start accepted

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic [LFSR_W-1:0] lfsr;
    logic              accept;
    logic              last;
    logic              seed_load_ok;
    logic              unused_lfsr;

    assign o_we         = (state == FILL);
    assign o_busy       = (state == FILL);
    assign o_addr       = addr;
    assign o_dat        = lfsr[LFSR_W-1 -: DATA_W];
    assign accept       = o_we && !i_stall;
    assign last         = (addr == LAST_ADDR);
    assign seed_load_ok = i_seed_load && (state != FILL);
    assign unused_lfsr  = ^lfsr;

    rand_fill_lfsr #(
        .LFSR_W (LFSR_W),
        .TAPS   (TAPS),
        .STEP   (DATA_W),
        .SEED   (SEED)
    ) u_lfsr (
        .clk     (i_clk),
        .rst_n   (i_rst_n),
        .load    (seed_load_ok),
        .seed    (i_seed),
        .advance (accept),
        .state   (lfsr)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
            addr  <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (i_start) begin
                        state <= FILL;
                        addr  <= '0;
                    end
                end
                FILL: begin
                    if (accept) begin
                        if (last) begin
                            addr <= '0;
`ifdef RAND_FILL_LOOP_EN
                            state <= FILL;
`else
                            state <= DONE;
`endif
                        end else begin
                            addr <= addr + ADDR_W'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    addr  <= '0;
                end
            endcase
        end
    end

`ifdef RAND_FILL_LOOP_EN
    // Looping never leaves FILL, so completion is flagged by a registered pulse instead.
    logic done_pulse;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            done_pulse <= 1'b0;
        end else begin
            done_pulse <= accept && last;
        end
    end

    assign o_done = done_pulse;
`else
    assign o_done = (state == DONE);
`endif

endmodule
